// File: rtl/jtopl_eg_regs.sv
// jtopl_eg_regs: OPL envelope register file; CPU writes in, slot-by-slot replay out to jtopl_eg.
// Define JTOPL_EG_REGS_READBACK_EN to add the dout readback port.
module jtopl_eg_regs #(
    parameter int unsigned SLOTS = 18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cenop,
    input  logic       zero,
    input  logic       cs_n,
    input  logic       wr_n,
    input  logic       addr,
    input  logic [7:0] din,
`ifdef JTOPL_EG_REGS_READBACK_EN
    output logic [7:0] dout,
`endif
    output logic       busy,
    output logic       en_sus_I,
    output logic [3:0] arate_I,
    output logic [3:0] drate_I,
    output logic [3:0] rrate_I,
    output logic [3:0] sl_I,
    output logic       keyon_I,
    output logic [9:0] fnum_I,
    output logic [2:0] block_I,
    output logic       ksr_II,
    output logic       amsen_IV,
    output logic [5:0] tl_IV,
    output logic [1:0] ksl_IV
);
    localparam int unsigned CHANS = SLOTS / 2;

    typedef enum logic { IDLE, WAIT } state_t;
    state_t state, state_nx;
    logic   wait_cnt, wait_cnt_nx;

    logic       wr_act, wr_last, we;
    logic [7:0] reg_sel, wr_sel, wr_data;
    logic       wr_pend;

    logic       amsen  [0:SLOTS-1];
    logic       en_sus [0:SLOTS-1];
    logic       ksr    [0:SLOTS-1];
    logic [1:0] ksl    [0:SLOTS-1];
    logic [5:0] tl     [0:SLOTS-1];
    logic [3:0] arate  [0:SLOTS-1];
    logic [3:0] drate  [0:SLOTS-1];
    logic [3:0] sl     [0:SLOTS-1];
    logic [3:0] rrate  [0:SLOTS-1];
    logic [9:0] fnum   [0:CHANS-1];
    logic [2:0] block  [0:CHANS-1];
    logic       keyon  [0:CHANS-1];

    logic [4:0] slot_I;
    logic [3:0] rp_ch;
    logic       ksr_I, amsen_I, amsen_II, amsen_III;
    logic [5:0] tl_I, tl_II, tl_III;
    logic [1:0] ksl_I, ksl_II, ksl_III;

    // Operator offsets come in groups of six, eight apart: 0-5, 8-13, 16-21
    function automatic logic op_valid(input logic [4:0] o);
        return (o[2:0] < 3'd6) && (o < 5'd22);
    endfunction

    function automatic logic [4:0] op_slot(input logic [4:0] o);
        return {3'b000, o[4:3]} * 5'd6 + {2'b00, o[2:0]};
    endfunction

    function automatic logic [3:0] slot_ch(input logic [4:0] s);
        logic [4:0] r;
        logic [3:0] base;
        if (s < 5'd6) begin
            base = 4'd0;
            r    = s;
        end else if (s < 5'd12) begin
            base = 4'd3;
            r    = s - 5'd6;
        end else begin
            base = 4'd6;
            r    = s - 5'd12;
        end
        if (r >= 5'd3) r = r - 5'd3;
        return base + r[3:0];
    endfunction

    assign wr_act = ~cs_n & ~wr_n;
    assign we     = wr_act & ~wr_last;

    // Data-port writes are captured here and committed to storage one clk later
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_last <= 1'b0;
            reg_sel <= '0;
            wr_pend <= 1'b0;
            wr_sel  <= '0;
            wr_data <= '0;
        end else begin
            wr_last <= wr_act;
            wr_pend <= we & addr;
            if (we) begin
                if (addr) begin
                    wr_sel  <= reg_sel;
                    wr_data <= din;
                end else begin
                    reg_sel <= din;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= 1'b0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        wait_cnt_nx = wait_cnt;
        busy        = (state == WAIT);
        if (we && addr) begin
            state_nx    = WAIT;
            wait_cnt_nx = 1'b0;
        end else if (state == WAIT && cenop) begin
            if (wait_cnt) begin
                state_nx    = IDLE;
                wait_cnt_nx = 1'b0;
            end else begin
                wait_cnt_nx = 1'b1;
            end
        end
    end

    logic       wr_op_ok, wr_ch_ok;
    logic [4:0] wr_slot;
    logic [3:0] wr_ch;

    always_comb begin
        wr_op_ok = op_valid(wr_sel[4:0]);
        wr_slot  = op_slot(wr_sel[4:0]);
        wr_ch    = wr_sel[3:0];
        wr_ch_ok = wr_sel[3:0] < 4'(CHANS);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < SLOTS; i++) begin
                amsen[i]  <= 1'b0;
                en_sus[i] <= 1'b0;
                ksr[i]    <= 1'b0;
                ksl[i]    <= '0;
                tl[i]     <= '0;
                arate[i]  <= '0;
                drate[i]  <= '0;
                sl[i]     <= '0;
                rrate[i]  <= '0;
            end
            for (int unsigned i = 0; i < CHANS; i++) begin
                fnum[i]  <= '0;
                block[i] <= '0;
                keyon[i] <= 1'b0;
            end
        end else if (wr_pend) begin
            case (wr_sel[7:5])
                3'd1: if (wr_op_ok) begin
                    amsen[wr_slot]  <= wr_data[6];
                    en_sus[wr_slot] <= wr_data[5];
                    ksr[wr_slot]    <= wr_data[4];
                end
                3'd2: if (wr_op_ok) begin
                    ksl[wr_slot] <= wr_data[7:6];
                    tl[wr_slot]  <= wr_data[5:0];
                end
                3'd3: if (wr_op_ok) begin
                    arate[wr_slot] <= wr_data[7:4];
                    drate[wr_slot] <= wr_data[3:0];
                end
                3'd4: if (wr_op_ok) begin
                    sl[wr_slot]    <= wr_data[7:4];
                    rrate[wr_slot] <= wr_data[3:0];
                end
                3'd5: if (wr_ch_ok) begin
                    if (wr_sel[4]) begin
                        keyon[wr_ch]     <= wr_data[5];
                        block[wr_ch]     <= wr_data[4:2];
                        fnum[wr_ch][9:8] <= wr_data[1:0];
                    end else begin
                        fnum[wr_ch][7:0] <= wr_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rp_ch = slot_ch(slot_I);

    // zero marks slot 0 at the counter, so the period after it presents slot 0
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_I    <= '0;
            en_sus_I  <= 1'b0;
            arate_I   <= '0;
            drate_I   <= '0;
            rrate_I   <= '0;
            sl_I      <= '0;
            keyon_I   <= 1'b0;
            fnum_I    <= '0;
            block_I   <= '0;
            ksr_I     <= 1'b0;
            ksr_II    <= 1'b0;
            amsen_I   <= 1'b0;
            amsen_II  <= 1'b0;
            amsen_III <= 1'b0;
            amsen_IV  <= 1'b0;
            tl_I      <= '0;
            tl_II     <= '0;
            tl_III    <= '0;
            tl_IV     <= '0;
            ksl_I     <= '0;
            ksl_II    <= '0;
            ksl_III   <= '0;
            ksl_IV    <= '0;
        end else if (cenop) begin
            if (zero)
                slot_I <= 5'd1;
            else if (slot_I == 5'(SLOTS - 1))
                slot_I <= '0;
            else
                slot_I <= slot_I + 5'd1;

            en_sus_I  <= en_sus[slot_I];
            arate_I   <= arate[slot_I];
            drate_I   <= drate[slot_I];
            rrate_I   <= rrate[slot_I];
            sl_I      <= sl[slot_I];
            keyon_I   <= keyon[rp_ch];
            fnum_I    <= fnum[rp_ch];
            block_I   <= block[rp_ch];

            ksr_I     <= ksr[slot_I];
            ksr_II    <= ksr_I;
            amsen_I   <= amsen[slot_I];
            amsen_II  <= amsen_I;
            amsen_III <= amsen_II;
            amsen_IV  <= amsen_III;
            tl_I      <= tl[slot_I];
            tl_II     <= tl_I;
            tl_III    <= tl_II;
            tl_IV     <= tl_III;
            ksl_I     <= ksl[slot_I];
            ksl_II    <= ksl_I;
            ksl_III   <= ksl_II;
            ksl_IV    <= ksl_III;
        end
    end

`ifdef JTOPL_EG_REGS_READBACK_EN
    logic [7:0] rd_byte;
    logic [4:0] rd_slot;
    logic [3:0] rd_ch;
    logic       rd_op_ok, rd_ch_ok;

    always_comb begin
        rd_byte  = '0;
        rd_slot  = op_slot(reg_sel[4:0]);
        rd_ch    = reg_sel[3:0];
        rd_op_ok = op_valid(reg_sel[4:0]);
        rd_ch_ok = reg_sel[3:0] < 4'(CHANS);
        case (reg_sel[7:5])
            3'd1: if (rd_op_ok) rd_byte = {1'b0, amsen[rd_slot], en_sus[rd_slot], ksr[rd_slot], 4'b0000};
            3'd2: if (rd_op_ok) rd_byte = {ksl[rd_slot], tl[rd_slot]};
            3'd3: if (rd_op_ok) rd_byte = {arate[rd_slot], drate[rd_slot]};
            3'd4: if (rd_op_ok) rd_byte = {sl[rd_slot], rrate[rd_slot]};
            3'd5: if (rd_ch_ok) begin
                if (reg_sel[4])
                    rd_byte = {2'b00, keyon[rd_ch], block[rd_ch], fnum[rd_ch][9:8]};
                else
                    rd_byte = fnum[rd_ch][7:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) dout <= '0;
        else     dout <= rd_byte;
    end
`endif

endmodule

// File: tb/tb_jtopl_eg_regs.sv
// Scoreboard bench for jtopl_eg_regs: directed CPU writes, expected slot replays queued and matched per cenop.
module tb_jtopl_eg_regs;
    logic       clk = 1'b0, rst = 1'b1, cenop = 1'b0, zero = 1'b0;
    logic       cs_n = 1'b1, wr_n = 1'b1, addr = 1'b0;
    logic [7:0] din = '0;
    logic       busy, en_sus_I, keyon_I, ksr_II, amsen_IV;
    logic [3:0] arate_I, drate_I, rrate_I, sl_I;
    logic [9:0] fnum_I;
    logic [2:0] block_I;
    logic [5:0] tl_IV;
    logic [1:0] ksl_IV;
`ifdef JTOPL_EG_REGS_READBACK_EN
    logic [7:0] dout;
`endif

    jtopl_eg_regs #(.SLOTS(18)) dut (
        .clk(clk), .rst(rst), .cenop(cenop), .zero(zero),
        .cs_n(cs_n), .wr_n(wr_n), .addr(addr), .din(din),
`ifdef JTOPL_EG_REGS_READBACK_EN
        .dout(dout),
`endif
        .busy(busy), .en_sus_I(en_sus_I), .arate_I(arate_I), .drate_I(drate_I),
        .rrate_I(rrate_I), .sl_I(sl_I), .keyon_I(keyon_I), .fnum_I(fnum_I),
        .block_I(block_I), .ksr_II(ksr_II), .amsen_IV(amsen_IV), .tl_IV(tl_IV),
        .ksl_IV(ksl_IV)
    );

    always #5 clk = ~clk;

    logic [31:0] act_I, act_IV;
    assign act_I  = {1'b0, en_sus_I, arate_I, drate_I, rrate_I, sl_I, keyon_I, fnum_I, block_I};
    assign act_IV = {23'b0, amsen_IV, ksl_IV, tl_IV};

    typedef struct {
        int          slot;
        int          kind;   // 0: stage I, 1: stage IV, 2: ksr_II
        logic [31:0] exp;
        string       name;
        int          born;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0, n_total = 0, cen_total = 0;

    function automatic logic [31:0] mk_I(input bit en, input logic [3:0] ar, input logic [3:0] dr,
                                         input logic [3:0] rr, input logic [3:0] s_l, input bit ko,
                                         input logic [9:0] fn, input logic [2:0] bl);
        return {1'b0, en, ar, dr, rr, s_l, ko, fn, bl};
    endfunction

    function automatic logic [31:0] mk_IV(input bit am, input logic [1:0] kl, input logic [5:0] t);
        return {23'b0, am, kl, t};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic push(input int slot, input int kind, input logic [31:0] e, input string nm);
        sb.push_back('{slot, kind, e, nm, cen_total});
    endtask

    // Operator clock enable every 4 clk; zero with every 18th cenop, realigned by reset
    initial begin
        int ccnt, ncen;
        ccnt = 0;
        ncen = 0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                ccnt = 0; ncen = 0; cenop = 1'b0; zero = 1'b0;
            end else begin
                cenop = (ccnt == 3);
                zero  = cenop && (ncen == 0);
                if (cenop) ncen = (ncen == 17) ? 0 : ncen + 1;
                ccnt = (ccnt + 1) % 4;
            end
        end
    end

    // Monitor: tracks which slot each stage presents and retires matching expectations
    initial begin
        int sc;
        int hist[4];
        sc = 0;
        hist = '{-1, -1, -1, -1};
        forever begin
            @(posedge clk);
            if (rst) begin
                sc = 0;
                hist = '{-1, -1, -1, -1};
            end else if (cenop) begin
                hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = sc;
                sc = zero ? 1 : ((sc == 17) ? 0 : sc + 1);
                cen_total++;
                #1;
                for (int i = sb.size() - 1; i >= 0; i--) begin
                    int          tgt;
                    logic [31:0] act;
                    case (sb[i].kind)
                        0:       begin tgt = hist[0]; act = act_I;           end
                        1:       begin tgt = hist[3]; act = act_IV;          end
                        default: begin tgt = hist[1]; act = {31'b0, ksr_II}; end
                    endcase
                    if (sb[i].slot == tgt) begin
                        check(sb[i].name, act, sb[i].exp);
                        sb.delete(i);
                    end else if (cen_total - sb[i].born > 60) begin
                        n_total++;
                        $display("FAIL %s: slot %0d never presented, expected 0x%0h", sb[i].name, sb[i].slot, sb[i].exp);
                        sb.delete(i);
                    end
                end
            end
        end
    end

    // Drives one CPU write; a data write must hold busy for exactly two cenops after detection
    task automatic cpu_write(input logic a, input logic [7:0] d, input int hold, input string nm);
        int n;
        bit fell;
        @(negedge clk);
        cs_n = 1'b0; wr_n = 1'b0; addr = a; din = d;
        @(posedge clk);
        n = 0;
        fell = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c >= hold) begin cs_n = 1'b1; wr_n = 1'b1; end
            if (c == 1) check({nm, " busy_rise"}, {31'b0, busy}, {31'b0, a});
            else if (a && !fell && !busy) begin
                fell = 1'b1;
                check({nm, " busy_cenops"}, n, 2);
            end
            @(posedge clk);
            if (cenop) n++;
        end
        if (a && !fell) begin
            n_total++;
            $display("FAIL %s busy_cenops: busy still high after 40 clk, expected drop at cenop 2", nm);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
        while (sb.size() != 0) begin
            n_total++;
            $display("FAIL %s: not checked within bound, expected 0x%0h", sb[0].name, sb[0].exp);
            sb.delete(0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset stage_I", act_I, 32'h0);
        check("reset stage_IV", act_IV, 32'h0);
        check("reset ksr_II", {31'b0, ksr_II}, 32'h0);
        check("reset busy", {31'b0, busy}, 32'h0);
        rst = 1'b0;

        cpu_write(1'b0, 8'h60, 1, "sel60");
        cpu_write(1'b1, 8'hF3, 1, "w60");
        push(0, 0, mk_I(0, 4'hF, 4'h3, 0, 0, 0, 0, 0), "t1 slot0_I");
        push(1, 0, 32'h0, "t1 slot1_I");
        push(6, 0, 32'h0, "t1 slot6_I");
        push(17, 0, 32'h0, "t1 slot17_I");
        push(0, 1, 32'h0, "t1 slot0_IV");
        wait_drain();

        cpu_write(1'b0, 8'h48, 1, "sel48");
        cpu_write(1'b1, 8'h9A, 1, "w48");
        push(6, 1, mk_IV(0, 2'd2, 6'h1A), "t2 slot6_IV");
        push(5, 1, 32'h0, "t2 slot5_IV");
        push(7, 1, 32'h0, "t2 slot7_IV");
        push(0, 0, mk_I(0, 4'hF, 4'h3, 0, 0, 0, 0, 0), "t2 slot0_I");
        wait_drain();

        cpu_write(1'b0, 8'hA4, 1, "selA4");
        cpu_write(1'b1, 8'h55, 1, "wA4");
        cpu_write(1'b0, 8'hB4, 1, "selB4");
        cpu_write(1'b1, 8'h2E, 1, "wB4");
        push(7, 0, mk_I(0, 0, 0, 0, 0, 1, 10'h255, 3'd3), "t3 slot7_I");
        push(10, 0, mk_I(0, 0, 0, 0, 0, 1, 10'h255, 3'd3), "t3 slot10_I");
        push(4, 0, 32'h0, "t3 slot4_I");
        wait_drain();

        cpu_write(1'b0, 8'h26, 1, "sel26");
        cpu_write(1'b1, 8'hFF, 1, "w26");
        push(5, 0, 32'h0, "t4 slot5_I");
        push(6, 0, 32'h0, "t4 slot6_I");
        push(6, 2, 32'h0, "t4 slot6_ksr");
        push(6, 1, mk_IV(0, 2'd2, 6'h1A), "t4 slot6_IV");
        push(0, 0, mk_I(0, 4'hF, 4'h3, 0, 0, 0, 0, 0), "t4 slot0_I");
        wait_drain();

        cpu_write(1'b0, 8'h8D, 1, "sel8D");
        cpu_write(1'b1, 8'h7C, 10, "w8D_held");
        cpu_write(1'b0, 8'h35, 1, "sel35");
        cpu_write(1'b1, 8'h70, 1, "w35");
        cpu_write(1'b0, 8'hA8, 1, "selA8");
        cpu_write(1'b1, 8'h81, 1, "wA8");
        cpu_write(1'b0, 8'hB8, 1, "selB8");
        cpu_write(1'b1, 8'h23, 1, "wB8");
        push(11, 0, mk_I(0, 0, 0, 4'hC, 4'h7, 0, 0, 0), "t5 slot11_I");
        push(17, 0, mk_I(1, 0, 0, 0, 0, 1, 10'h381, 3'd0), "t5 slot17_I");
        push(17, 2, 32'h1, "t5 slot17_ksr");
        push(17, 1, mk_IV(1, 0, 0), "t5 slot17_IV");
        push(14, 0, mk_I(0, 0, 0, 0, 0, 1, 10'h381, 3'd0), "t5 slot14_I");
        push(16, 0, 32'h0, "t5 slot16_I");
        wait_drain();

        // Reset lands on the edge where the pending data write would commit
        cpu_write(1'b0, 8'h61, 1, "sel61");
        @(negedge clk);
        cs_n = 1'b0; wr_n = 1'b0; addr = 1'b1; din = 8'hAB;
        @(negedge clk);
        cs_n = 1'b1; wr_n = 1'b1;
        check("t6 busy_midwait", {31'b0, busy}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check("t6 rst stage_I", act_I, 32'h0);
        check("t6 rst stage_IV", act_IV, 32'h0);
        check("t6 rst busy", {31'b0, busy}, 32'h0);
        rst = 1'b0;
        push(0, 0, 32'h0, "t6 slot0_I");
        push(1, 0, 32'h0, "t6 slot1_I");
        push(7, 0, 32'h0, "t6 slot7_I");
        push(11, 0, 32'h0, "t6 slot11_I");
        push(17, 0, 32'h0, "t6 slot17_I");
        push(17, 2, 32'h0, "t6 slot17_ksr");
        push(6, 1, 32'h0, "t6 slot6_IV");
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
